// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks register use in a
// shadow EX/MEM/WB pipeline, raises stall/flush and selects EX operand bypass sources.
module hazard_fwd_ctrl #(
  parameter int FW_EN  = 1,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr_id,
  input  logic             i_inst_vld_id,
  input  logic             i_pc_sel_ex,
  output logic             o_enable_pc,
  output logic             o_enable_if,
  output logic             o_flush_if,
  output logic             o_flush_id,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0]       SEL_RF  = 2'b00;
  localparam logic [1:0]       SEL_MEM = 2'b01;
  localparam logic [1:0]       SEL_WB  = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]        id_op;
  logic [REG_AW-1:0] id_rd, id_rs1, id_rs2;
  logic              id_use_rs1, id_use_rs2, id_wr, id_ld;
  logic              unused_instr;

  logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic              ex_wr, ex_ld, mem_wr, wb_wr;

  logic              ex_hit, mem_hit, stall_raw, flush, stall, bubble_ex;

  assign id_op  = i_instr_id[6:0];
  assign id_rd  = i_instr_id[7 +: REG_AW];
  assign id_rs1 = i_instr_id[15 +: REG_AW];
  assign id_rs2 = i_instr_id[20 +: REG_AW];
  // funct fields and immediates are irrelevant to hazard detection
  assign unused_instr = ^i_instr_id;

  always_comb begin
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_wr      = 1'b0;
    id_ld      = 1'b0;
    if (i_inst_vld_id) begin
      case (id_op)
        OP_R:   begin id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; id_wr = 1'b1; end
        OP_I:   begin id_use_rs1 = 1'b1; id_wr = 1'b1; end
        OP_LD:  begin id_use_rs1 = 1'b1; id_wr = 1'b1; id_ld = 1'b1; end
        OP_ST:  begin id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; end
        OP_BR:  begin id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; end
        OP_JLR: begin id_use_rs1 = 1'b1; id_wr = 1'b1; end
        OP_LUI: id_wr = 1'b1;
        OP_AUI: id_wr = 1'b1;
        OP_JAL: id_wr = 1'b1;
        default: ;
      endcase
    end
  end

  function automatic logic reads_from(input logic wr, input logic [REG_AW-1:0] rd,
                                      input logic u1, input logic [REG_AW-1:0] r1,
                                      input logic u2, input logic [REG_AW-1:0] r2);
    return wr && (rd != '0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic m_wr, input logic [REG_AW-1:0] m_rd,
                                         input logic w_wr, input logic [REG_AW-1:0] w_rd);
    if (m_wr && (m_rd != '0) && (m_rd == rs))      return SEL_MEM;
    else if (w_wr && (w_rd != '0) && (w_rd == rs)) return SEL_WB;
    else                                           return SEL_RF;
  endfunction

  always_comb begin
    ex_hit  = reads_from(ex_wr, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
    mem_hit = reads_from(mem_wr, mem_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
    if (FW_EN != 0) stall_raw = ex_ld && ex_hit;
    else            stall_raw = ex_hit || mem_hit;
  end

  // a taken branch squashes the stalled consumer anyway, so flush wins
  assign flush     = i_pc_sel_ex && !i_reset;
  assign stall     = stall_raw && !flush && !i_reset;
  assign bubble_ex = stall || flush;

  assign o_enable_pc = !stall;
  assign o_enable_if = !stall;
  assign o_flush_if  = flush;
  assign o_flush_id  = bubble_ex;

  always_comb begin
    o_fwd_a_sel = SEL_RF;
    o_fwd_b_sel = SEL_RF;
    if (FW_EN != 0) begin
      o_fwd_a_sel = fwd_sel(ex_rs1, mem_wr, mem_rd, wb_wr, wb_rd);
      o_fwd_b_sel = fwd_sel(ex_rs2, mem_wr, mem_rd, wb_wr, wb_rd);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_rd  <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_wr  <= 1'b0;
      ex_ld  <= 1'b0;
      mem_rd <= '0;
      mem_wr <= 1'b0;
      wb_rd  <= '0;
      wb_wr  <= 1'b0;
    end else begin
      if (bubble_ex) begin
        ex_rd  <= '0;
        ex_rs1 <= '0;
        ex_rs2 <= '0;
        ex_wr  <= 1'b0;
        ex_ld  <= 1'b0;
      end else begin
        // unused source fields are zeroed so they can never match a producer
        ex_rd  <= id_wr ? id_rd : '0;
        ex_rs1 <= id_use_rs1 ? id_rs1 : '0;
        ex_rs2 <= id_use_rs2 ? id_rs2 : '0;
        ex_wr  <= id_wr;
        ex_ld  <= id_ld;
      end
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (stall && (o_stall_cnt != CNT_MAX)) o_stall_cnt <= o_stall_cnt + CNT_ONE;
      if (flush && (o_flush_cnt != CNT_MAX)) o_flush_cnt <= o_flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Checks hazard_fwd_ctrl (forwarding, interlock and 2-bit-counter variants) against a
// list-of-instructions reference model under directed and random stimulus.
module tb_hazard_fwd_ctrl;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_instr_id;
  logic        i_inst_vld_id, i_pc_sel_ex;

  logic f1_en_pc, f1_en_if, f1_fl_if, f1_fl_id; logic [1:0] f1_fa, f1_fb; logic [31:0] f1_sc, f1_fc;
  logic f0_en_pc, f0_en_if, f0_fl_if, f0_fl_id; logic [1:0] f0_fa, f0_fb; logic [31:0] f0_sc, f0_fc;
  logic s2_en_pc, s2_en_if, s2_fl_if, s2_fl_id; logic [1:0] s2_fa, s2_fb; logic [1:0]  s2_sc, s2_fc;

  hazard_fwd_ctrl #(.FW_EN(1), .REG_AW(5), .CNT_W(32)) u_fw1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr_id(i_instr_id), .i_inst_vld_id(i_inst_vld_id),
    .i_pc_sel_ex(i_pc_sel_ex), .o_enable_pc(f1_en_pc), .o_enable_if(f1_en_if), .o_flush_if(f1_fl_if),
    .o_flush_id(f1_fl_id), .o_fwd_a_sel(f1_fa), .o_fwd_b_sel(f1_fb), .o_stall_cnt(f1_sc), .o_flush_cnt(f1_fc));
  hazard_fwd_ctrl #(.FW_EN(0), .REG_AW(5), .CNT_W(32)) u_fw0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr_id(i_instr_id), .i_inst_vld_id(i_inst_vld_id),
    .i_pc_sel_ex(i_pc_sel_ex), .o_enable_pc(f0_en_pc), .o_enable_if(f0_en_if), .o_flush_if(f0_fl_if),
    .o_flush_id(f0_fl_id), .o_fwd_a_sel(f0_fa), .o_fwd_b_sel(f0_fb), .o_stall_cnt(f0_sc), .o_flush_cnt(f0_fc));
  hazard_fwd_ctrl #(.FW_EN(1), .REG_AW(5), .CNT_W(2)) u_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr_id(i_instr_id), .i_inst_vld_id(i_inst_vld_id),
    .i_pc_sel_ex(i_pc_sel_ex), .o_enable_pc(s2_en_pc), .o_enable_if(s2_en_if), .o_flush_if(s2_fl_if),
    .o_flush_id(s2_fl_id), .o_fwd_a_sel(s2_fa), .o_fwd_b_sel(s2_fb), .o_stall_cnt(s2_sc), .o_flush_cnt(s2_fc));

  always #10 i_clk = ~i_clk;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BR = 7'b1100011, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;

  // rd = -1: no register written; rs = -1: operand not read
  typedef struct {bit ld; int rd; int rs1; int rs2;} ent_t;

  ent_t   pipe [2][3];   // [model: 0 forwarding, 1 interlock][0 EX, 1 MEM, 2 WB]
  ent_t   e_id;
  longint scnt [2];
  longint fcnt;
  bit     e_stall [2];
  bit     e_flush, in_rst;
  int     e_fa, e_fb;
  int     tests = 0, fails = 0;

  bit c_stall, c_stall0, c_enpc, r_enpc, r_flid;
  logic [1:0] c_fa, c_fb;
  longint c_sc1, c_fc1, c_sc0, r_sc;

  function automatic ent_t bubble();
    ent_t e;
    e.ld = 0; e.rd = -1; e.rs1 = -1; e.rs2 = -1;
    return e;
  endfunction

  function automatic ent_t dec(logic [31:0] ins, logic v);
    ent_t e;
    logic [6:0] op;
    e = bubble();
    op = ins[6:0];
    if (v) begin
      if (op inside {OP_R, OP_I, LOAD, STORE, BR, JALR})        e.rs1 = int'(ins[19:15]);
      if (op inside {OP_R, STORE, BR})                          e.rs2 = int'(ins[24:20]);
      if (op inside {OP_R, OP_I, LOAD, LUI, AUIPC, JAL, JALR})  e.rd  = int'(ins[11:7]);
      e.ld = (op == LOAD);
    end
    return e;
  endfunction

  function automatic bit reads(ent_t c, ent_t p);
    return p.rd > 0 && (c.rs1 == p.rd || c.rs2 == p.rd);
  endfunction

  function automatic int fsel(int r);
    if (r < 0) return 0;
    if (pipe[0][1].rd > 0 && pipe[0][1].rd == r) return 1;
    if (pipe[0][2].rd > 0 && pipe[0][2].rd == r) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 3; k++) pipe[m][k] = bubble();
      scnt[m] = 0;
    end
    fcnt = 0;
  endtask

  task automatic check_all();
    longint s2s, s2f;
    in_rst = i_reset;
    if (in_rst) model_reset();
    e_id       = dec(i_instr_id, i_inst_vld_id);
    e_flush    = !in_rst && i_pc_sel_ex;
    e_stall[0] = !in_rst && !e_flush && pipe[0][0].ld && reads(e_id, pipe[0][0]);
    e_stall[1] = !in_rst && !e_flush && (reads(e_id, pipe[1][0]) || reads(e_id, pipe[1][1]));
    e_fa = fsel(pipe[0][0].rs1);
    e_fb = fsel(pipe[0][0].rs2);
    s2s = (scnt[0] > 3) ? 3 : scnt[0];
    s2f = (fcnt > 3) ? 3 : fcnt;
    chk("f1_enable_pc", f1_en_pc, !e_stall[0]);
    chk("f1_enable_if", f1_en_if, !e_stall[0]);
    chk("f1_flush_if",  f1_fl_if, e_flush);
    chk("f1_flush_id",  f1_fl_id, e_flush || e_stall[0]);
    chk("f1_fwd_a",     f1_fa, e_fa);
    chk("f1_fwd_b",     f1_fb, e_fb);
    chk("f1_stall_cnt", f1_sc, scnt[0]);
    chk("f1_flush_cnt", f1_fc, fcnt);
    chk("f0_enable_pc", f0_en_pc, !e_stall[1]);
    chk("f0_enable_if", f0_en_if, !e_stall[1]);
    chk("f0_flush_if",  f0_fl_if, e_flush);
    chk("f0_flush_id",  f0_fl_id, e_flush || e_stall[1]);
    chk("f0_fwd_a",     f0_fa, 0);
    chk("f0_fwd_b",     f0_fb, 0);
    chk("f0_stall_cnt", f0_sc, scnt[1]);
    chk("f0_flush_cnt", f0_fc, fcnt);
    chk("s2_enable_pc", s2_en_pc, !e_stall[0]);
    chk("s2_fwd_a",     s2_fa, e_fa);
    chk("s2_stall_cnt", s2_sc, s2s);
    chk("s2_flush_cnt", s2_fc, s2f);
  endtask

  task automatic model_update();
    if (in_rst) return;
    for (int m = 0; m < 2; m++) begin
      pipe[m][2] = pipe[m][1];
      pipe[m][1] = pipe[m][0];
      pipe[m][0] = (e_stall[m] || e_flush) ? bubble() : e_id;
      scnt[m] += longint'(e_stall[m]);
    end
    fcnt += longint'(e_flush);
  endtask

  // Called in the low clock phase: drive, check, optionally pulse reset, then clock once.
  task automatic cycle(logic [31:0] instr, logic vld, logic pcs, bit rst_mid);
    i_instr_id = instr; i_inst_vld_id = vld; i_pc_sel_ex = pcs;
    #1;
    check_all();
    c_stall = !f1_en_pc; c_stall0 = !f0_en_pc; c_enpc = f1_en_pc;
    c_fa = f1_fa; c_fb = f1_fb; c_sc1 = f1_sc; c_fc1 = f1_fc; c_sc0 = f0_sc;
    if (rst_mid) begin
      #2 i_reset = 1'b1;
      #1;
      check_all();
      r_enpc = f1_en_pc; r_flid = f1_fl_id; r_sc = f1_sc;
      #2 i_reset = 1'b0;
      #1;
      check_all();
    end
    @(posedge i_clk);
    model_update();
    @(negedge i_clk);
  endtask

  localparam logic [31:0] NOP = 32'd0;

  initial begin
    logic [6:0] ops [10];
    ops = '{OP_R, OP_I, LOAD, STORE, BR, JALR, LUI, AUIPC, JAL, 7'h7f};
    i_reset = 1'b1; i_instr_id = '0; i_inst_vld_id = 1'b0; i_pc_sel_ex = 1'b1;
    model_reset();
    #3;
    check_all();
    chk("rst_enable_pc", f1_en_pc, 1);
    chk("rst_flush_if", f1_fl_if, 0);
    chk("rst_stall_cnt", f1_sc, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // back-to-back ALU dependency: bypass from MEM, then from WB
    cycle(enc(OP_R, 1, 2, 3), 1, 0, 0);
    cycle(enc(OP_R, 2, 1, 3), 1, 0, 0); chk("A_no_stall", c_stall, 0);
    cycle(enc(OP_R, 4, 1, 0), 1, 0, 0); chk("A_fwd_mem", c_fa, 1);
    cycle(NOP, 0, 0, 0);                chk("A_fwd_wb", c_fa, 2);

    // load-use: one stall then WB bypass on both operands
    cycle(NOP, 0, 0, 1);
    cycle(enc(LOAD, 5, 0, 0), 1, 0, 0);
    cycle(enc(OP_R, 6, 5, 5), 1, 0, 0); chk("B_stall", c_stall, 1);
    cycle(enc(OP_R, 6, 5, 5), 1, 0, 0); chk("B_released", c_stall, 0);
    cycle(NOP, 0, 0, 0);
    chk("B_fwd_a", c_fa, 2); chk("B_fwd_b", c_fb, 2); chk("B_stall_cnt", c_sc1, 1);

    // interlock variant: two stall cycles
    cycle(NOP, 0, 0, 1);
    cycle(enc(OP_R, 1, 2, 3), 1, 0, 0);
    cycle(enc(OP_R, 2, 1, 1), 1, 0, 0); chk("C_stall1", c_stall0, 1);
    cycle(enc(OP_R, 2, 1, 1), 1, 0, 0); chk("C_stall2", c_stall0, 1);
    cycle(enc(OP_R, 2, 1, 1), 1, 0, 0); chk("C_released", c_stall0, 0);
    cycle(NOP, 0, 0, 0);                chk("C_stall_cnt", c_sc0, 2);

    // flush overrides a load-use stall
    cycle(NOP, 0, 0, 1);
    cycle(enc(LOAD, 5, 0, 0), 1, 0, 0);
    cycle(enc(OP_R, 6, 5, 5), 1, 1, 0); chk("D_enable_pc", c_enpc, 1);
    cycle(NOP, 0, 0, 0);
    chk("D_flush_cnt", c_fc1, 1); chk("D_stall_cnt", c_sc1, 0);

    // x0 is never a hazard source
    cycle(NOP, 0, 0, 1);
    cycle(enc(OP_R, 0, 1, 2), 1, 0, 0);
    cycle(enc(OP_R, 3, 0, 0), 1, 0, 0); chk("E_no_stall_alu", c_stall0, 0);
    cycle(enc(LOAD, 0, 1, 0), 1, 0, 0);
    cycle(enc(OP_R, 4, 0, 0), 1, 0, 0); chk("E_no_stall_ld", c_stall, 0);
    cycle(NOP, 0, 0, 0);                chk("E_no_fwd", c_fa, 0);

    // random traffic on a small register window to provoke hazards
    cycle(NOP, 0, 0, 1);
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle(ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 0);
    end
    chk("sat_flush_cnt", s2_fc, 3);

    // reset pulse in the middle of a load-use stall
    cycle(NOP, 0, 0, 0); cycle(NOP, 0, 0, 0); cycle(NOP, 0, 0, 0);
    cycle(enc(LOAD, 5, 0, 0), 1, 0, 0);
    cycle(enc(OP_R, 6, 5, 5), 1, 0, 1);
    chk("F_stall_before", c_stall, 1);
    chk("F_rst_enable_pc", r_enpc, 1);
    chk("F_rst_flush_id", r_flid, 0);
    chk("F_rst_stall_cnt", r_sc, 0);
    cycle(NOP, 0, 0, 0);
    chk("F_no_stale_a", c_fa, 0); chk("F_no_stale_b", c_fb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
